// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: default widths, timeout
// budget and the access FSM state encoding.
package mem_stage_pkg;

    localparam int DEF_DMEM_ADDR_WIDTH   = 12;
    localparam int DEF_DMEM_WORD_WIDTH   = 16;
    localparam int DEF_IALU_WORD_WIDTH   = 16;
    localparam int DEF_PC_WIDTH          = 12;
    localparam int DEF_PMEM_WORD_WIDTH   = 16;
    localparam int DEF_REG_IDX_WIDTH     = 4;
    localparam int DEF_TIMEOUT_CYCLES    = 15;
    localparam int DEF_TIMEOUT_CNT_WIDTH = 4;
    localparam int PC_INCREMENT          = 1;

    // IDLE: a new instruction sits in the input registers.
    // WAIT: a DMEM request is outstanding and the pipe is frozen.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding DMEM request. Clear has priority
// over enable; o_terminal flags that the timeout budget is used up.
module mem_wait_timer
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = DEF_TIMEOUT_CNT_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    logic [CNT_WIDTH-1:0] r_count;

    // Count wait cycles; cleared whenever no request is pending.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_terminal = (r_count == CNT_WIDTH'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the EX outputs, runs the DMEM req/ack
// access, stalls upstream while waiting, aborts after a timeout and hands a
// registered register-file write to write-back.
// Optional load-data bypass to DC is enabled by defining MEM_LOAD_FWD_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH   = DEF_DMEM_ADDR_WIDTH,
    parameter int DMEM_WORD_WIDTH   = DEF_DMEM_WORD_WIDTH,
    parameter int IALU_WORD_WIDTH   = DEF_IALU_WORD_WIDTH,
    parameter int PC_WIDTH          = DEF_PC_WIDTH,
    parameter int PMEM_WORD_WIDTH   = DEF_PMEM_WORD_WIDTH,
    parameter int REG_IDX_WIDTH     = DEF_REG_IDX_WIDTH,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
    parameter int TIMEOUT_CNT_WIDTH = DEF_TIMEOUT_CNT_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic                       in_dmem_ack,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rdata,
    output logic                       out_dmem_req,
    output logic                       out_dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wdata,
    output logic                       out_stall,
    output logic                       out_bus_err,
    output logic                       out_reg_wr_en,
    output logic [REG_IDX_WIDTH-1:0]   out_reg_wr_idx,
    output logic [IALU_WORD_WIDTH-1:0] out_reg_wr_data,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic                       out_fwd_valid,
    output logic [REG_IDX_WIDTH-1:0]   out_fwd_idx,
    output logic [IALU_WORD_WIDTH-1:0] out_fwd_data
);

    // Input registers (the instruction currently owned by this stage).
    logic                       r_load;
    logic                       r_store;
    logic                       r_write_res;
    logic [DMEM_ADDR_WIDTH-1:0] r_rd_addr;
    logic [DMEM_ADDR_WIDTH-1:0] r_wr_addr;
    logic [DMEM_WORD_WIDTH-1:0] r_wr_word;
    logic [PMEM_WORD_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]        r_pc;
    logic [IALU_WORD_WIDTH-1:0] r_res;
    logic [REG_IDX_WIDTH-1:0]   r_res_reg_idx;

    mem_state_e r_state;
    mem_state_e w_state_next;

    logic w_store;
    logic w_load;
    logic w_access;
    logic w_req;
    logic w_stall;
    logic w_abort;
    logic w_tmr_clear;
    logic w_tmr_en;
    logic w_tmr_terminal;

    // A simultaneous load and store resolves to the store.
    assign w_store  = r_store;
    assign w_load   = r_load & ~r_store;
    assign w_access = w_store | w_load;

    assign w_req = ((r_state == ST_IDLE) && w_access) || (r_state == ST_WAIT);

    assign out_dmem_req   = w_req;
    assign out_dmem_we    = w_req & w_store;
    assign out_dmem_addr  = w_req ? (w_store ? r_wr_addr : r_rd_addr) : '0;
    assign out_dmem_wdata = (w_req && w_store) ? r_wr_word : '0;
    assign out_stall      = w_stall;

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (TIMEOUT_CNT_WIDTH)
    ) u_wait_timer (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (w_tmr_clear),
        .i_enable   (w_tmr_en),
        .o_terminal (w_tmr_terminal)
    );

    // Next state, stall, abort and timer control for the access FSM.
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_abort      = 1'b0;
        w_tmr_clear  = 1'b0;
        w_tmr_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access && !in_dmem_ack) begin
                    w_state_next = ST_WAIT;
                    w_stall      = 1'b1;
                    w_tmr_en     = 1'b1;
                end else begin
                    w_tmr_clear  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (in_dmem_ack) begin
                    w_state_next = ST_IDLE;
                    w_tmr_clear  = 1'b1;
                end else if (w_tmr_terminal) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                    w_tmr_clear  = 1'b1;
                end else begin
                    w_stall      = 1'b1;
                    w_tmr_en     = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tmr_clear  = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the EX outputs whenever the pipe advances; hold during a stall.
    // NOTE: these are plain registers, not a memory array, so all of them
    // take the reset and the stage starts from a clean bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_load        <= 1'b0;
            r_store       <= 1'b0;
            r_write_res   <= 1'b0;
            r_rd_addr     <= '0;
            r_wr_addr     <= '0;
            r_wr_word     <= '0;
            r_instr       <= '0;
            r_pc          <= '0;
            r_res         <= '0;
            r_res_reg_idx <= '0;
        end else if (!w_stall) begin
            r_load        <= in_act_load_dmem;
            r_store       <= in_act_store_dmem;
            r_write_res   <= in_act_write_res_to_reg;
            r_rd_addr     <= in_dmem_rd_addr;
            r_wr_addr     <= in_dmem_wr_addr;
            r_wr_word     <= in_dmem_wr_word;
            r_instr       <= in_instr;
            r_pc          <= in_pc;
            r_res         <= in_res;
            r_res_reg_idx <= in_res_reg_idx;
        end
    end

    // Sticky bus-error flag, set by a timeout abort, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_bus_err <= 1'b0;
        end else if (w_abort) begin
            out_bus_err <= 1'b1;
        end
    end

    // Write-back register: retire the instruction on completion, bubble while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_reg_wr_en   <= 1'b0;
            out_reg_wr_idx  <= '0;
            out_reg_wr_data <= '0;
            out_instr       <= '0;
            out_pc          <= '0;
        end else if (w_stall) begin
            out_reg_wr_en   <= 1'b0;
            out_reg_wr_idx  <= '0;
            out_reg_wr_data <= '0;
            out_instr       <= '0;
            out_pc          <= '0;
        end else begin
            out_reg_wr_en   <= r_write_res & ~(w_abort & w_load);
            out_reg_wr_idx  <= r_res_reg_idx;
            out_reg_wr_data <= w_load ? in_dmem_rdata : r_res;
            out_instr       <= r_instr;
            out_pc          <= r_pc;
        end
    end

`ifdef MEM_LOAD_FWD_EN
    // A load with write-back is acknowledged this cycle: hand its data to DC
    // one cycle before it reaches the register file. An ack in WAIT always
    // wins over the timeout, so an acked load is never an aborted one.
    assign out_fwd_valid = w_load & r_write_res & in_dmem_ack;
    assign out_fwd_idx   = out_fwd_valid ? r_res_reg_idx : '0;
    assign out_fwd_data  = out_fwd_valid ? in_dmem_rdata : '0;
`else
    assign out_fwd_valid = 1'b0;
    assign out_fwd_idx   = '0;
    assign out_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_mem_stage;

    localparam int TIMEOUT = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_act_load_dmem = 1'b0;
    logic        in_act_store_dmem = 1'b0;
    logic        in_act_write_res_to_reg = 1'b0;
    logic [11:0] in_dmem_rd_addr = '0;
    logic [11:0] in_dmem_wr_addr = '0;
    logic [15:0] in_dmem_wr_word = '0;
    logic [15:0] in_instr = '0;
    logic [11:0] in_pc = '0;
    logic [15:0] in_res = '0;
    logic [3:0]  in_res_reg_idx = '0;
    logic        in_dmem_ack = 1'b0;
    logic [15:0] in_dmem_rdata = '0;
    logic        out_dmem_req, out_dmem_we, out_stall, out_bus_err;
    logic [11:0] out_dmem_addr, out_pc;
    logic [15:0] out_dmem_wdata, out_reg_wr_data, out_instr, out_fwd_data;
    logic        out_reg_wr_en, out_fwd_valid;
    logic [3:0]  out_reg_wr_idx, out_fwd_idx;

    mem_stage dut (
        .clock                   (clock),
        .reset                   (reset),
        .in_act_load_dmem        (in_act_load_dmem),
        .in_act_store_dmem       (in_act_store_dmem),
        .in_act_write_res_to_reg (in_act_write_res_to_reg),
        .in_dmem_rd_addr         (in_dmem_rd_addr),
        .in_dmem_wr_addr         (in_dmem_wr_addr),
        .in_dmem_wr_word         (in_dmem_wr_word),
        .in_instr                (in_instr),
        .in_pc                   (in_pc),
        .in_res                  (in_res),
        .in_res_reg_idx          (in_res_reg_idx),
        .in_dmem_ack             (in_dmem_ack),
        .in_dmem_rdata           (in_dmem_rdata),
        .out_dmem_req            (out_dmem_req),
        .out_dmem_we             (out_dmem_we),
        .out_dmem_addr           (out_dmem_addr),
        .out_dmem_wdata          (out_dmem_wdata),
        .out_stall               (out_stall),
        .out_bus_err             (out_bus_err),
        .out_reg_wr_en           (out_reg_wr_en),
        .out_reg_wr_idx          (out_reg_wr_idx),
        .out_reg_wr_data         (out_reg_wr_data),
        .out_instr               (out_instr),
        .out_pc                  (out_pc),
        .out_fwd_valid           (out_fwd_valid),
        .out_fwd_idx             (out_fwd_idx),
        .out_fwd_data            (out_fwd_data)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One instruction as seen by the model: EX fields plus DMEM ack latency
    // (cycles after the first request cycle; > TIMEOUT means never acked).
    typedef struct {
        bit          v;
        bit          load, store, wres;
        logic [11:0] rd_addr, wr_addr, pc;
        logic [15:0] wr_word, instr, res;
        logic [3:0]  idx;
        int          lat;
    } op_t;

    function automatic op_t nop_op();
        op_t o;
        o.v = 0; o.load = 0; o.store = 0; o.wres = 0;
        o.rd_addr = '0; o.wr_addr = '0; o.pc = '0;
        o.wr_word = '0; o.instr = '0; o.res = '0; o.idx = '0; o.lat = 0;
        return o;
    endfunction

    function automatic op_t mk_op(bit ld, bit st, bit wr, logic [11:0] ra, logic [11:0] wa,
                                  logic [15:0] wd, logic [15:0] rs, logic [3:0] ix, int lat);
        op_t o = nop_op();
        o.v = 1; o.load = ld; o.store = st; o.wres = wr;
        o.rd_addr = ra; o.wr_addr = wa; o.wr_word = wd; o.res = rs; o.idx = ix;
        o.instr = 16'($urandom); o.pc = 12'($urandom); o.lat = lat;
        return o;
    endfunction

    function automatic op_t rand_op();
        int k = $urandom_range(0, 99);
        int r = $urandom_range(0, 99);
        int lat;
        if (r < 55)      lat = 0;
        else if (r < 85) lat = $urandom_range(1, 4);
        else if (r < 95) lat = $urandom_range(5, TIMEOUT);
        else             lat = 99;
        return mk_op(k >= 40 && k < 70 || k >= 90, k >= 70, 1'($urandom),
                     12'($urandom), 12'($urandom), 16'($urandom), 16'($urandom),
                     4'($urandom), lat);
    endfunction

    task automatic drive_ex(input op_t o);
        in_act_load_dmem        = o.load;
        in_act_store_dmem       = o.store;
        in_act_write_res_to_reg = o.wres;
        in_dmem_rd_addr         = o.rd_addr;
        in_dmem_wr_addr         = o.wr_addr;
        in_dmem_wr_word         = o.wr_word;
        in_instr                = o.instr;
        in_pc                   = o.pc;
        in_res                  = o.res;
        in_res_reg_idx          = o.idx;
    endtask

    // Model state: instruction in the stage, instruction on EX, cycles waited.
    op_t cur, nxt;
    op_t q[$];
    int  w = 0;
    bit  err_model = 0;
    int  stall_cycles = 0;

    // One clock of the transaction model: the stage's instruction needs
    // min(lat, TIMEOUT) stall cycles, then retires (aborted if lat > TIMEOUT).
    task automatic step();
        bit access, is_load, completing, aborted, ack, exp_fv;
        int stop;
        logic [15:0] rd;
        @(negedge clock);
        drive_ex(nxt);
        access     = cur.load || cur.store;
        is_load    = cur.load && !cur.store;
        stop       = (cur.lat < TIMEOUT) ? cur.lat : TIMEOUT;
        completing = !access || (w == stop);
        aborted    = access && completing && (cur.lat > TIMEOUT);
        ack        = access ? (w == cur.lat) : ($urandom_range(0, 3) == 0);
        rd         = 16'($urandom);
        in_dmem_ack   = ack;
        in_dmem_rdata = rd;
        #1;
        check("req", out_dmem_req, access);
        check("we", out_dmem_we, access && cur.store);
        check("addr", out_dmem_addr, !access ? 12'h0 : (cur.store ? cur.wr_addr : cur.rd_addr));
        check("wdata", out_dmem_wdata, (access && cur.store) ? cur.wr_word : 16'h0);
        check("stall", out_stall, !completing);
        if (out_stall) stall_cycles++;
`ifdef MEM_LOAD_FWD_EN
        exp_fv = is_load && cur.wres && ack;
        check("fwd_valid", out_fwd_valid, exp_fv);
        if (exp_fv) begin
            check("fwd_idx", out_fwd_idx, cur.idx);
            check("fwd_data", out_fwd_data, rd);
        end
`else
        exp_fv = 1'b0;
        check("fwd_valid", out_fwd_valid, exp_fv);
        check("fwd_idx", out_fwd_idx, 4'h0);
        check("fwd_data", out_fwd_data, 16'h0);
`endif
        @(posedge clock);
        #1;
        if (completing) begin
            if (aborted) err_model = 1;
            check("wb_en", out_reg_wr_en, cur.wres && !(aborted && is_load));
            check("wb_idx", out_reg_wr_idx, cur.idx);
            check("wb_instr", out_instr, cur.instr);
            check("wb_pc", out_pc, cur.pc);
            if (!(aborted && is_load)) check("wb_data", out_reg_wr_data, is_load ? rd : cur.res);
            cur = nxt;
            if (q.size() != 0) nxt = q.pop_front();
            else nxt = nop_op();
            w = 0;
        end else begin
            check("bubble_en", out_reg_wr_en, 1'b0);
            check("bubble_idx", out_reg_wr_idx, 4'h0);
            check("bubble_data", out_reg_wr_data, 16'h0);
            check("bubble_instr", out_instr, 16'h0);
            check("bubble_pc", out_pc, 12'h0);
            w++;
        end
        check("bus_err", out_bus_err, err_model);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((q.size() != 0 || nxt.v || cur.v) && guard < 500) begin
            step();
            guard++;
        end
        check(tag, guard < 500, 1'b1);
    endtask

    // Directed single-cycle vectors: every access is acked in its issue cycle.
    typedef struct {
        op_t         op;
        bit          ack;
        logic [15:0] rdata;
        bit          e_req, e_we, e_en, e_fwd;
        logic [11:0] e_addr;
        logic [15:0] e_wdata, e_data;
    } vec_t;

    function automatic vec_t mkv(op_t o, bit ack, logic [15:0] rdata, bit e_req, bit e_we,
                                 logic [11:0] e_addr, logic [15:0] e_wdata, bit e_en,
                                 logic [15:0] e_data, bit e_fwd);
        vec_t v;
        v.op = o; v.ack = ack; v.rdata = rdata; v.e_req = e_req; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_en = e_en; v.e_data = e_data; v.e_fwd = e_fwd;
        return v;
    endfunction

    localparam int NV = 10;
    vec_t vec[NV];

    initial begin
        vec[0] = mkv(mk_op(1, 0, 1, 12'h010, 12'h000, 16'h0000, 16'h0000, 4'd3, 0), 1, 16'hBEEF,
                     1, 0, 12'h010, 16'h0000, 1, 16'hBEEF, 1);
        vec[1] = mkv(mk_op(0, 0, 1, 12'h000, 12'h000, 16'h0000, 16'h00A5, 4'd7, 0), 0, 16'h0000,
                     0, 0, 12'h000, 16'h0000, 1, 16'h00A5, 0);
        vec[2] = mkv(mk_op(0, 0, 1, 12'h3C3, 12'h0AA, 16'h1111, 16'h5A5A, 4'd8, 0), 1, 16'hDEAD,
                     0, 0, 12'h000, 16'h0000, 1, 16'h5A5A, 0);
        vec[3] = mkv(mk_op(0, 1, 0, 12'h0FF, 12'h020, 16'h1234, 16'h0042, 4'd1, 0), 1, 16'h2222,
                     1, 1, 12'h020, 16'h1234, 0, 16'h0042, 0);
        vec[4] = mkv(mk_op(1, 1, 0, 12'h033, 12'h044, 16'hCAFE, 16'h0007, 4'd2, 0), 1, 16'h9999,
                     1, 1, 12'h044, 16'hCAFE, 0, 16'h0007, 0);
        vec[5] = mkv(mk_op(1, 0, 0, 12'hABC, 12'h000, 16'h0000, 16'h0001, 4'd4, 0), 1, 16'h4321,
                     1, 0, 12'hABC, 16'h0000, 0, 16'h4321, 0);
        vec[6] = mkv(mk_op(1, 0, 1, 12'h005, 12'h000, 16'h0000, 16'h0000, 4'd5, 0), 1, 16'h7777,
                     1, 0, 12'h005, 16'h0000, 1, 16'h7777, 1);
        vec[7] = mkv(mk_op(0, 0, 0, 12'h000, 12'h000, 16'h0000, 16'hFFFF, 4'd15, 0), 0, 16'h0000,
                     0, 0, 12'h000, 16'h0000, 0, 16'hFFFF, 0);
        vec[8] = mkv(nop_op(), 0, 16'h0, 0, 0, 12'h0, 16'h0, 0, 16'h0, 0);
        vec[9] = mkv(nop_op(), 0, 16'h0, 0, 0, 12'h0, 16'h0, 0, 16'h0, 0);

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", out_dmem_req, 1'b0);
        check("rst_stall", out_stall, 1'b0);
        check("rst_bus_err", out_bus_err, 1'b0);
        check("rst_wb_en", out_reg_wr_en, 1'b0);
        check("rst_wb_data", out_reg_wr_data, 16'h0);
        check("rst_pc", out_pc, 12'h0);
        @(negedge clock);
        reset = 1'b0;

        // Vector table: vec[c] on EX, vec[c-1] in the stage, retiring to WB.
        for (int c = 0; c < NV; c++) begin
            @(negedge clock);
            drive_ex(vec[c].op);
            in_dmem_ack   = (c > 0) ? vec[c-1].ack : 1'b0;
            in_dmem_rdata = (c > 0) ? vec[c-1].rdata : 16'h0;
            #1;
            if (c > 0) begin
                check("tv_req", out_dmem_req, vec[c-1].e_req);
                check("tv_we", out_dmem_we, vec[c-1].e_we);
                check("tv_addr", out_dmem_addr, vec[c-1].e_addr);
                check("tv_wdata", out_dmem_wdata, vec[c-1].e_wdata);
                check("tv_stall", out_stall, 1'b0);
`ifdef MEM_LOAD_FWD_EN
                check("tv_fwd_valid", out_fwd_valid, vec[c-1].e_fwd);
                if (vec[c-1].e_fwd) begin
                    check("tv_fwd_idx", out_fwd_idx, vec[c-1].op.idx);
                    check("tv_fwd_data", out_fwd_data, vec[c-1].rdata);
                end
`else
                check("tv_fwd_valid", out_fwd_valid, 1'b0);
                check("tv_fwd_data", out_fwd_data, 16'h0);
`endif
            end
            @(posedge clock);
            #1;
            if (c > 0) begin
                check("tv_wb_en", out_reg_wr_en, vec[c-1].e_en);
                check("tv_wb_idx", out_reg_wr_idx, vec[c-1].op.idx);
                check("tv_wb_data", out_reg_wr_data, vec[c-1].e_data);
                check("tv_wb_instr", out_instr, vec[c-1].op.instr);
                check("tv_wb_pc", out_pc, vec[c-1].op.pc);
            end
        end

        cur = nop_op();
        nxt = nop_op();
        w   = 0;

        // Store acked three cycles after issue.
        stall_cycles = 0;
        q.push_back(mk_op(0, 1, 1, 12'h000, 12'h020, 16'h1234, 16'h0055, 4'd6, 3));
        drain("drain_store");
        check("store_stall_cycles", stall_cycles, 3);

        // Load that is never acked, followed by an ALU op that must proceed.
        stall_cycles = 0;
        q.push_back(mk_op(1, 0, 1, 12'h100, 12'h000, 16'h0000, 16'h0000, 4'd9, 99));
        q.push_back(mk_op(0, 0, 1, 12'h000, 12'h000, 16'h0000, 16'h0BAD, 4'd2, 0));
        drain("drain_timeout");
        check("timeout_stall_cycles", stall_cycles, TIMEOUT);
        step();
        check("bus_err_sticky", out_bus_err, 1'b1);

        // Reset while waiting on DMEM.
        q.push_back(mk_op(1, 0, 1, 12'h200, 12'h000, 16'h0000, 16'h0000, 4'd11, 99));
        for (int k = 0; k < 12 && !(cur.v && w == 3); k++) step();
        check("reached_wait", w, 3);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("rstw_req", out_dmem_req, 1'b0);
        check("rstw_stall", out_stall, 1'b0);
        check("rstw_bus_err", out_bus_err, 1'b0);
        check("rstw_wb_en", out_reg_wr_en, 1'b0);
        check("rstw_wb_idx", out_reg_wr_idx, 4'h0);
        check("rstw_pc", out_pc, 12'h0);
        @(negedge clock);
        reset     = 1'b0;
        cur       = nop_op();
        w         = 0;
        err_model = 0;
        q.push_back(mk_op(1, 0, 1, 12'h005, 12'h000, 16'h0000, 16'h0000, 4'd5, 0));
        drain("drain_after_reset");

        // Randomized traffic.
        for (int i = 0; i < 150; i++) q.push_back(rand_op());
        drain("drain_random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the EX outputs: load/store strobes, DMEM addresses and store word, ALU result, destination register index, instr and pc.
- Performs the data-memory access over a req/ack handshake and stalls the upstream pipe while DMEM has not acknowledged.
- Presents a registered register-file write (index/data/enable) to write-back.

Parameters:
DMEM_ADDR_WIDTH, 12, DMEM address width
DMEM_WORD_WIDTH, 16, DMEM data width
IALU_WORD_WIDTH, 16, ALU result width (equals DMEM_WORD_WIDTH)
PC_WIDTH, 12, program counter width
PMEM_WORD_WIDTH, 16, instruction word width
REG_IDX_WIDTH, 4, register index width
TIMEOUT_CYCLES, 15, max wait cycles for ack before abort
TIMEOUT_CNT_WIDTH, 4, width of wait counter (must hold TIMEOUT_CYCLES)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
in_act_load_dmem  in  1  EX requests load
in_act_store_dmem  in  1  EX requests store
in_act_write_res_to_reg  in  1  EX result/load data goes to register file
in_dmem_rd_addr  in  DMEM_ADDR_WIDTH  load address
in_dmem_wr_addr  in  DMEM_ADDR_WIDTH  store address
in_dmem_wr_word  in  DMEM_WORD_WIDTH  store data
in_instr  in  PMEM_WORD_WIDTH  instruction (debug/trace)
in_pc  in  PC_WIDTH  instruction pc
in_res  in  IALU_WORD_WIDTH  EX result
in_res_reg_idx  in  REG_IDX_WIDTH  destination register
in_dmem_ack  in  1  DMEM completes current request this cycle
in_dmem_rdata  in  DMEM_WORD_WIDTH  load data, valid with ack
out_dmem_req  out  1  access request
out_dmem_we  out  1  1 = write, 0 = read
out_dmem_addr  out  DMEM_ADDR_WIDTH  access address
out_dmem_wdata  out  DMEM_WORD_WIDTH  write data
out_stall  out  1  hold IF/DC/EX and this stage's input registers
out_bus_err  out  1  sticky timeout flag
out_reg_wr_en  out  1  register write enable to WB
out_reg_wr_idx  out  REG_IDX_WIDTH  register write index
out_reg_wr_data  out  IALU_WORD_WIDTH  register write data
out_instr  out  PMEM_WORD_WIDTH  instruction to WB
out_pc  out  PC_WIDTH  pc to WB
out_fwd_valid  out  1  load-data bypass valid (optional feature)
out_fwd_idx  out  REG_IDX_WIDTH  bypass index
out_fwd_data  out  IALU_WORD_WIDTH  bypass data

Behaviour:
- Reset:
  - All input registers, FSM (IDLE), wait counter and out_bus_err clear to 0 immediately, including mid-access.
  - out_dmem_req drops in the same instant.
  - All registered outputs are 0.
- Input registers load every posedge when out_stall=0; they hold when out_stall=1.
- Access selection:
  - Store when store_ff=1. If load_ff and store_ff are both 1, the store wins and the load is ignored.
  - Load when load_ff=1 only.
  - Otherwise no access.
- DMEM drive (combinational from registers):
  - req = (state==IDLE && access) || state==WAIT.
  - we = store.
  - addr = wr_addr_ff for a store, rd_addr_ff for a load.
  - wdata = wr_word_ff for a store, else 0.
  - All DMEM outputs are 0 when req=0.
- FSM IDLE:
  - access && ack: completes with zero added latency; no stall.
  - access && !ack: out_stall=1, go to WAIT, counter=1.
- FSM WAIT:
  - out_stall=1, req held with addr/data stable.
  - ack: complete, go to IDLE, out_stall=0 in that cycle.
  - !ack && counter==TIMEOUT_CYCLES: abort. Drop req next cycle, set out_bus_err, go to IDLE, out_stall=0 in that cycle.
  - Otherwise counter++.
- Completion (posedge at the end of the completing cycle):
  - out_reg_wr_en <= write_res_ff && !aborted_load.
  - out_reg_wr_idx <= res_reg_idx_ff.
  - out_reg_wr_data <= in_dmem_rdata for a load, res_ff otherwise.
  - out_instr and out_pc are passed through.
- Stage latency = 1 cycle plus DMEM wait cycles.
- While stalled, each posedge writes out_reg_wr_en=0 (bubble to WB); idx/data/instr/pc are 0.
- Non-memory instructions complete in IDLE every cycle.
- ack while req=0 is ignored.
- out_bus_err stays 1 until reset.

Optional Feature:
MEM_LOAD_FWD_EN
- Defined: combinational bypass in the completing cycle of a non-aborted load with write_res_ff=1.
  - out_fwd_valid=1.
  - out_fwd_idx=res_reg_idx_ff.
  - out_fwd_data=in_dmem_rdata.
  - This lets DC consume load data one cycle early.
- Undefined: out_fwd_valid, out_fwd_idx and out_fwd_data are tied to 0; the ports remain present.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, WAIT=1).
  - Default widths.
  - PC_INCREMENT and TIMEOUT default.
- Natural sub-module: mem_wait_timer (counter with clear/enable, terminal-count output).

Test Plan:
- Load, ack in issue cycle: addr 0x010, rdata 0xBEEF, idx 3, write_res=1 -> no stall; next cycle wr_en=1, idx=3, data=0xBEEF.
- Store, ack after 3 cycles: addr 0x020, word 0x1234 -> req/we/addr/wdata stable for 4 cycles, stall=1 for 3; WB bubbles, then wr_en=write_res_ff.
- ALU op with res 0x00A5, idx 7, no mem -> req=0, data 0x00A5 one cycle later; back-to-back ops stream without stall.
- Load, ack never arrives -> stall for 15 cycles, then req=0, bus_err=1 sticky, wr_en=0; the following instruction proceeds.
- Reset asserted during WAIT -> req=0 and stall=0 immediately, FSM=IDLE, outputs 0; after release a new load completes normally.
- MEM_LOAD_FWD_EN defined: load into idx 5 with rdata 0x7777 -> fwd_valid=1, idx=5, data=0x7777 in the ack cycle; undefined -> fwd ports 0.
